sort_unique_engine: RTL and testbench

//  Streaming sort-and-deduplicate engine: accepts up to DEPTH words over a valid/ready input,

---
 rtl/sort_unique_engine_pkg.sv | 17 +
 rtl/sort_unique_engine_cx.sv | 21 ++
 rtl/sort_unique_engine.sv | 177 +++++++++++++++++
 tb/tb_sort_unique_engine.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sort_unique_engine_pkg.sv
// Shared types and helpers for the sort-and-deduplicate engine.
// Holds the control state encoding and the compare-exchange swap decision.
package sort_unique_engine_pkg;

  typedef enum logic [1:0] {
    S_LOAD,
    S_SORT,
    S_DEDUP,
    S_DRAIN
  } state_t;

  // Equal operands never swap, so the sort is stable for duplicate keys.
  function automatic logic cx_swap(input logic a_gt_b, input logic a_lt_b, input logic desc);
    return desc ? a_lt_b : a_gt_b;
  endfunction

endpackage

// File: rtl/sort_unique_engine_cx.sv
// Combinational compare-exchange cell: lo lands at the lower array index, hi at the upper.
// With desc set the larger value goes to lo, giving descending order across the array.
module sort_unique_engine_cx
  import sort_unique_engine_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             desc,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic swap;

  assign swap = cx_swap(a > b, a < b, desc);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/sort_unique_engine.sv
// Streaming sort-and-deduplicate engine: load up to DEPTH words, odd-even transposition
// sort in place, optionally compact duplicates, then stream the result out.
//
//   state   | meaning
//   S_LOAD  | accept input words into A[0..n-1]
//   S_SORT  | n odd-even transposition phases, one per cycle
//   S_DEDUP | in-place compaction of duplicates, one element per cycle
//   S_DRAIN | stream A[0..m-1] out with out_last on the final word
module sort_unique_engine
  import sort_unique_engine_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             cfg_desc,
  input  logic             cfg_uniq,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] uniq_count,
  output logic             busy,
  output logic             overflow
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t state, state_nxt;

  logic [WIDTH-1:0] arr      [DEPTH];
  logic [WIDTH-1:0] sort_nxt [DEPTH];
  logic [WIDTH-1:0] cx_lo    [DEPTH-1];
  logic [WIDTH-1:0] cx_hi    [DEPTH-1];

  logic [CNT_W-1:0] n, m, k, r, p;
  logic [CNT_W-1:0] n_inc;
  logic             desc_q, uniq_q, ovf_q;
  logic             in_hs, out_hs;
  logic             load_done, sort_done, dedup_done, drain_done;
  logic             keep;

  assign in_hs      = in_valid & in_ready;
  assign out_hs     = out_valid & out_ready;
  assign n_inc      = n + CNT_W'(1);
  assign load_done  = in_hs & (in_last | (n_inc == CNT_W'(DEPTH)));
  assign sort_done  = (p == n - CNT_W'(1));
  assign dedup_done = (k == n - CNT_W'(1));
  assign drain_done = out_hs & out_last;

  // A[m-1] is the last kept element; only read once k > 0 so m >= 1.
  assign keep = (k == '0) || (arr[IDX_W'(k)] != arr[IDX_W'(m - CNT_W'(1))]);

  assign out_last   = (state == S_DRAIN) && (r == m - CNT_W'(1));
  assign out_data   = (state == S_DRAIN) ? arr[IDX_W'(r)] : '0;
  assign uniq_count = m;
  assign overflow   = ovf_q;

  for (genvar gi = 0; gi < DEPTH - 1; gi++) begin : g_cx
    sort_unique_engine_cx #(.WIDTH(WIDTH)) u_cx (
      .a   (arr[gi]),
      .b   (arr[gi+1]),
      .desc(desc_q),
      .lo  (cx_lo[gi]),
      .hi  (cx_hi[gi])
    );
  end

  // Phase parity picks which disjoint set of pairs is written back this cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) sort_nxt[i] = arr[i];
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (((i % 2) == int'(p[0])) && ((i + 1) < int'(n))) begin
        sort_nxt[i]   = cx_lo[i];
        sort_nxt[i+1] = cx_hi[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (load_done) state_nxt = S_SORT;
      end
      S_SORT: begin
        busy = 1'b1;
        if (sort_done) state_nxt = uniq_q ? S_DEDUP : S_DRAIN;
      end
      S_DEDUP: begin
        busy = 1'b1;
        if (dedup_done) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (drain_done) state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) arr[i] <= '0;
      n      <= '0;
      m      <= '0;
      k      <= '0;
      r      <= '0;
      p      <= '0;
      desc_q <= 1'b0;
      uniq_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_hs) begin
            arr[IDX_W'(n)] <= in_data;
            n              <= n_inc;
            if (n == '0) begin
              desc_q <= cfg_desc;
              uniq_q <= cfg_uniq;
              m      <= '0;
              ovf_q  <= 1'b0;
            end
            if (load_done) begin
              p     <= '0;
              ovf_q <= ~in_last;
            end
          end
        end
        S_SORT: begin
          for (int i = 0; i < DEPTH; i++) arr[i] <= sort_nxt[i];
          p <= p + CNT_W'(1);
          if (sort_done) begin
            k <= '0;
            if (!uniq_q) m <= n;
          end
        end
        S_DEDUP: begin
          if (keep) begin
            arr[IDX_W'(m)] <= arr[IDX_W'(k)];
            m              <= m + CNT_W'(1);
          end
          k <= k + CNT_W'(1);
        end
        S_DRAIN: begin
          if (out_hs) begin
            if (out_last) begin
              n <= '0;
              r <= '0;
            end else begin
              r <= r + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_unique_engine.sv
// Directed bench for sort_unique_engine: a reference sort/dedup model fills a scoreboard
// queue at load time and the drained output stream is popped and compared against it.
module tb_sort_unique_engine;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             cfg_desc;
  logic             cfg_uniq;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [CNT_W-1:0] uniq_count;
  logic             busy;
  logic             overflow;

  int tests  = 0;
  int failed = 0;
  int exp_q[$];
  int exp_m;

  sort_unique_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .cfg_desc  (cfg_desc),
    .cfg_uniq  (cfg_uniq),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .uniq_count(uniq_count),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input int w[$], input bit desc, input bit uniq);
    int s[$];
    int t;
    s = w;
    for (int i = 1; i < s.size(); i++) begin
      for (int j = i; j > 0; j--) begin
        if (desc ? (s[j] > s[j-1]) : (s[j] < s[j-1])) begin
          t      = s[j];
          s[j]   = s[j-1];
          s[j-1] = t;
        end
      end
    end
    exp_q.delete();
    for (int i = 0; i < s.size(); i++) begin
      if (!uniq || exp_q.size() == 0 || exp_q[$] != s[i]) exp_q.push_back(s[i]);
    end
    exp_m = exp_q.size();
  endtask

  // cfg inputs flip after the first word to show they are sampled only once.
  task automatic load_job(input int w[$], input bit desc, input bit uniq, input bit mark_last);
    build_exp(w, desc, uniq);
    for (int i = 0; i < w.size(); i++) begin
      @(negedge clk);
      if (i == 0) check("in_ready_load", in_ready, 1);
      in_valid = 1'b1;
      in_data  = WIDTH'(w[i]);
      in_last  = mark_last && (i == w.size() - 1);
      cfg_desc = (i == 0) ? desc : ~desc;
      cfg_uniq = (i == 0) ? uniq : ~uniq;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    cfg_desc = 1'b0;
    cfg_uniq = 1'b0;
  endtask

  task automatic drain_job(input string tag, input bit stall, input bit junk,
                           input int exp_lat, input bit exp_ovf);
    int               cyc;
    int               budget;
    int               e;
    bit               held_v;
    logic [WIDTH-1:0] held;
    cyc = 1;
    check({tag, "_in_ready_busy"}, in_ready, 0);
    if (junk) begin
      in_valid = 1'b1;
      in_data  = 8'hC3;
      in_last  = 1'b1;
    end
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_uniq_count"}, uniq_count, exp_m);
    check({tag, "_overflow"}, overflow, exp_ovf);
    check({tag, "_busy"}, busy, 1);
    held_v = 1'b0;
    held   = '0;
    budget = 0;
    while (exp_q.size() > 0 && budget < 500) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      check({tag, "_out_valid"}, out_valid, 1);
      if (held_v) check({tag, "_stall_hold"}, out_data, held);
      if (out_ready) begin
        e = exp_q.pop_front();
        check({tag, "_data"}, out_data, e);
        check({tag, "_last"}, out_last, (exp_q.size() == 0) ? 1 : 0);
        held_v = 1'b0;
      end else begin
        held_v = 1'b1;
        held   = out_data;
      end
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() > 0) check({tag, "_drain_timeout"}, exp_q.size(), 0);
    out_ready = 1'b0;
    check({tag, "_idle_out_valid"}, out_valid, 0);
    check({tag, "_idle_in_ready"}, in_ready, 1);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_hold_count"}, uniq_count, exp_m);
  endtask

  initial begin
    int w[$];
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    cfg_desc  = 1'b0;
    cfg_uniq  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_uniq_count", uniq_count, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);

    w = '{8, 1, 8, 1, 8, 1, 8, 1};
    load_job(w, 1'b0, 1'b1, 1'b1);
    drain_job("t1_asc_uniq", 1'b0, 1'b0, 2 * 8 + 1, 1'b0);

    load_job(w, 1'b0, 1'b0, 1'b1);
    drain_job("t2_asc_dup", 1'b0, 1'b0, 8 + 1, 1'b0);

    w = '{3, 7, 3, 0, 7};
    load_job(w, 1'b1, 1'b1, 1'b1);
    drain_job("t3_desc_uniq", 1'b0, 1'b1, 2 * 5 + 1, 1'b0);

    w.delete();
    for (int i = 15; i >= 0; i--) w.push_back(i);
    load_job(w, 1'b0, 1'b0, 1'b0);
    drain_job("t4_overflow", 1'b0, 1'b0, 16 + 1, 1'b1);

    w.delete();
    for (int i = 0; i < 12; i++) w.push_back(int'($urandom_range(0, 7)));
    load_job(w, 1'b1, 1'b1, 1'b1);
    drain_job("t5_stall", 1'b1, 1'b0, 2 * 12 + 1, 1'b0);

    w = '{9, 4, 200, 4, 17, 60};
    load_job(w, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("t6_busy_pre_rst", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_in_ready", in_ready, 1);
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_uniq_count", uniq_count, 0);
    rst = 1'b0;
    w = '{5};
    load_job(w, 1'b0, 1'b1, 1'b1);
    drain_job("t6_single", 1'b0, 1'b0, 2 * 1 + 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
